// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
//
// Arbitrates two Avalon-style masters onto a single RAM-side slave port.
// Master 0 is the instruction-fetch port, master 1 is the data port.
// Each grant carries exactly one transfer. The FSM then returns to IDLE, so
// back-to-back transfers from the same master always have one idle cycle
// between them.
//
// Configuration macro:
//   MIPS_BUS_ARB_ROUND_ROBIN_EN
//     Defined   : when both masters request together, the master that did
//                 not complete the most recent transfer wins. After reset,
//                 m0 wins the first tie.
//     Undefined : ties always go to m1 (data over fetch). No pointer
//                 register exists in this build.
//
// Parameters:
//   MAX_WAIT         slave-stall cycles allowed before a transfer is aborted
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   mN_address       master N byte address                    (N = 0, 1)
//   mN_read/write    master N request; read+write together counts as a write
//   mN_writedata     master N write data
//   mN_byteenable    master N byte lanes
//   mN_waitrequest   stall back to master N
//   mN_readdata      slave read data, forwarded to both masters
//   s_*              RAM-side request and response
//   grant            one-hot owner (01 = m0, 10 = m1, 00 = idle)
//   bus_error        sticky stall-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mips_bus_arbiter #(
  parameter int MAX_WAIT = 256
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,

  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,

  output logic [1:0]  grant,
  output logic        bus_error
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  state_t          cur_state;
  logic [CW-1:0]   stall_cnt;

  logic            req0;
  logic            req1;
  logic            pick_m1;
  logic            own_m1;
  logic            own_read;
  logic            own_write;
  logic            own_req;
  logic            timeout;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Read data is never muxed: both masters see the slave bus directly.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  logic prefer_m1;
  logic done;

  assign pick_m1 = prefer_m1;
  assign done    = (cur_state != IDLE) && own_req && !timeout && !s_waitrequest;

  // The pointer moves only on a completed transfer. Dropped requests and
  // timeouts leave it where it was.
  always_ff @(posedge clk) begin
    if (reset)
      prefer_m1 <= 1'b0;
    else if (done)
      prefer_m1 <= ~own_m1;
  end
`else
  assign pick_m1 = 1'b1;
`endif

  // Reset gates the output decode, so the slave sees no request while reset
  // is high, even if a grant was in flight.
  // NOTE: every signal written in this block gets a default at the top. A
  // path that leaves a variable unassigned would infer a latch.
  always_comb begin
    cur_state      = reset ? IDLE : state;
    own_m1         = (cur_state == GRANT1);
    own_read       = own_m1 ? m1_read  : m0_read;
    own_write      = own_m1 ? m1_write : m0_write;
    own_req        = own_read | own_write;

    next_state     = state;
    grant          = 2'b00;
    timeout        = 1'b0;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = req0;
    m1_waitrequest = req1;

    case (cur_state)
      IDLE: begin
        if (req0 && req1)
          next_state = pick_m1 ? GRANT1 : GRANT0;
        else if (req1)
          next_state = GRANT1;
        else if (req0)
          next_state = GRANT0;
        else
          next_state = IDLE;
      end

      GRANT0, GRANT1: begin
        grant        = own_m1 ? 2'b10 : 2'b01;
        // stall_cnt holds the stalls seen so far, so this grant cycle is the
        // MAX_WAIT-th one. The decision is registered and does not look at
        // s_waitrequest, which keeps the slave out of a combinational loop.
        timeout      = own_req && (stall_cnt >= CW'(MAX_WAIT - 1));
        s_address    = own_m1 ? m1_address    : m0_address;
        s_writedata  = own_m1 ? m1_writedata  : m0_writedata;
        s_byteenable = own_m1 ? m1_byteenable : m0_byteenable;
        s_write      = own_write & ~timeout;
        s_read       = own_read & ~own_write & ~timeout;

        if (own_m1)
          m1_waitrequest = timeout ? 1'b0 : s_waitrequest;
        else
          m0_waitrequest = timeout ? 1'b0 : s_waitrequest;

        if (!own_req || timeout || !s_waitrequest)
          next_state = IDLE;
      end

      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Each register
  // then reads the pre-edge value of every other register, as the hardware does.
  // NOTE: the reset is synchronous and is the highest-priority branch. It
  // aborts any grant in progress on the edge where it is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= next_state;

      // IDLE always precedes a grant, so clearing the counter here means it
      // starts every grant at zero.
      if (state == IDLE)
        stall_cnt <= '0;
      else if (s_waitrequest && (stall_cnt != CW'(MAX_WAIT)))
        stall_cnt <= stall_cnt + 1'b1;

      if (timeout)
        bus_error <= 1'b1;
    end
  end

endmodule
